// File: rtl/ls194_universal_shift_register.sv
// 74LS194-style universal shift register: hold, shift toward Q[WIDTH-1] (SR in),
// shift toward Q[0] (SL in), and parallel load. Async active-low clear.
module ls194_universal_shift_register #(
  parameter int WIDTH = 6
) (
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic [1:0]       S,
  input  logic             SR,
  input  logic             SL,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             QA_OUT,
  output logic             QH_OUT
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    case (S)
      2'b00:   q_d = q_q;
      2'b01:   q_d = {q_q[WIDTH-2:0], SR};
      2'b10:   q_d = {SL, q_q[WIDTH-1:1]};
      2'b11:   q_d = D;
      // Unknown mode select must not fabricate a plausible state.
      default: q_d = 'x;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign Q      = q_q;
  assign QA_OUT = q_q[0];
  assign QH_OUT = q_q[WIDTH-1];

endmodule
